// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB4 completer backed by a word-addressed register array.
// Byte-strobed writes, programmable wait states, error responses for bad accesses.
`default_nettype none

module apb_slave_mem #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
   parameter int                    SEL_WIDTH  = 1,
   parameter int                    SEL_IDX    = 0,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    DEPTH      = 256
) (
   input  logic                  pclk,
   input  logic                  prstn,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [SEL_WIDTH-1:0]  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [DATA_WIDTH-1:0] pwdata,
   input  logic [STRB_WIDTH-1:0] pstrb,
   input  logic [3:0]            wait_cfg,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr
);

   localparam int                IDX_W     = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(DEPTH * 4);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   state_t                state_q,  state_d;
   logic [3:0]            wcnt_q,   wcnt_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
   logic                  pwrite_q, pwrite_d;
   logic [IDX_W-1:0]      idx_q,    idx_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [STRB_WIDTH-1:0] pstrb_q,  pstrb_d;
   logic                  err_q,    err_d;

   logic                  sel;
   logic [ADDR_WIDTH-1:0] off;
   logic [IDX_W-1:0]      idx;
   logic                  setup_err;
   logic                  mem_we;

   assign sel = psel[SEL_IDX];
   // Offset wraps modulo 2^ADDR_WIDTH, so addresses below BASE_ADDR land out of range.
   assign off = paddr - BASE_ADDR;
   assign idx = off[2 +: IDX_W];

   assign setup_err = (paddr[1:0] != 2'b00)
                    | ({1'b0, off} >= MEM_BYTES)
                    | (!pwrite && (pstrb != '0));

   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      prdata_d = prdata_q;
      pwrite_d = pwrite_q;
      idx_d    = idx_q;
      pwdata_d = pwdata_q;
      pstrb_d  = pstrb_q;
      err_d    = err_q;
      mem_we   = 1'b0;

      case (state_q)
         IDLE: begin
            if (sel && !penable) begin
               pwrite_d = pwrite;
               idx_d    = idx;
               pwdata_d = pwdata;
               pstrb_d  = pstrb;
               wcnt_d   = wait_cfg;
               err_d    = setup_err;
               prdata_d = (!pwrite && !setup_err) ? mem[idx] : '0;
               state_d  = ACCESS;
            end
         end
         ACCESS: begin
            if (!sel) begin
               state_d  = IDLE;
               prdata_d = '0;
            end else if (penable) begin
               if (wcnt_q != 4'd0) begin
                  wcnt_d = wcnt_q - 4'd1;
               end else begin
                  state_d = IDLE;
                  mem_we  = pwrite_q && !err_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!prstn) begin
         state_q  <= IDLE;
         wcnt_q   <= 4'd0;
         prdata_q <= '0;
         pwrite_q <= 1'b0;
         idx_q    <= '0;
         pwdata_q <= '0;
         pstrb_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         prdata_q <= prdata_d;
         pwrite_q <= pwrite_d;
         idx_q    <= idx_d;
         pwdata_q <= pwdata_d;
         pstrb_q  <= pstrb_d;
         err_q    <= err_d;
      end
   end

   // Contents are deliberately not reset; a reset edge suppresses any pending commit.
   always_ff @(posedge pclk) begin
      if (prstn && mem_we) begin
         for (int b = 0; b < STRB_WIDTH; b++) begin
            if (pstrb_q[b]) begin
               mem[idx_q][8*b +: 8] <= pwdata_q[8*b +: 8];
            end
         end
      end
   end

   assign pready  = (state_q == ACCESS) && (wcnt_q == 4'd0);
   assign pslverr = pready && err_q;
   assign prdata  = prdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
// Directed self-checking bench for apb_slave_mem (DEPTH=256, BASE_ADDR=0).
`default_nettype none

module tb_apb_slave_mem;

   logic        pclk = 1'b0;
   logic        prstn;
   logic [31:0] paddr;
   logic [0:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [3:0]  wait_cfg;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   int checks = 0;
   int errors = 0;

   apb_slave_mem #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(1), .SEL_IDX(0),
      .BASE_ADDR(32'h0), .DEPTH(256)
   ) dut (
      .pclk(pclk), .prstn(prstn), .paddr(paddr), .psel(psel),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .wait_cfg(wait_cfg), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 pclk = ~pclk;

   // One transfer; returns at posedge+1 after completion with psel/penable still high.
   // Bus inputs are scrambled during ACCESS so only setup-phase values may matter.
   task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [3:0] wcfg,
                           output int waits, output logic err, output logic [31:0] rd);
      logic done;
      paddr = addr; pwrite = wr; pwdata = data; pstrb = strb; wait_cfg = wcfg;
      psel = 1'b1; penable = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
      paddr = ~addr; pwrite = ~wr; pwdata = ~data; pstrb = ~strb; wait_cfg = 4'hF;
      waits = 0; err = 1'bx; rd = 'x; done = 1'b0;
      for (int i = 0; i < 32 && !done; i++) begin
         @(negedge pclk);
         if (pready) begin
            err = pslverr; rd = prdata; done = 1'b1;
         end else begin
            waits++;
         end
         @(posedge pclk); #1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL xfer_timeout addr=%h got no pready, required pready within 32 cycles", addr);
      end
   endtask

   task automatic bus_idle();
      psel = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
   endtask

   task automatic test_reset();
      prstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0; wait_cfg = '0;
      repeat (3) @(posedge pclk);
      #1;
      @(negedge pclk);
      checks++; if (pready !== 1'b0) begin errors++; $display("FAIL reset_pready got %b required 0", pready); end
      checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr got %b required 0", pslverr); end
      checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata got %h required 0", prdata); end
      @(posedge pclk); #1;
      prstn = 1'b1;
      @(posedge pclk); #1;
   endtask

   task automatic test_zero_wait();
      int w; logic e; logic [31:0] r;
      apb_xfer(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 4'd0, w, e, r);
      checks++; if (w !== 0) begin errors++; $display("FAIL zw_write_waits got %0d required 0", w); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL zw_write_err got %b required 0", e); end
      bus_idle();
      apb_xfer(1'b0, 32'h100, 32'h0, 4'h0, 4'd0, w, e, r);
      checks++; if (w !== 0) begin errors++; $display("FAIL zw_read_waits got %0d required 0", w); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL zw_read_err got %b required 0", e); end
      checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL zw_read_data got %h required deadbeef", r); end
      bus_idle();
      @(negedge pclk);
      checks++; if (prdata !== 32'hDEADBEEF) begin errors++; $display("FAIL prdata_hold got %h required deadbeef", prdata); end
      @(posedge pclk); #1;
   endtask

   task automatic test_strobes();
      int w; logic e; logic [31:0] r;
      apb_xfer(1'b1, 32'h100, 32'h11223344, 4'b0101, 4'd0, w, e, r);
      bus_idle();
      apb_xfer(1'b0, 32'h100, 32'h0, 4'h0, 4'd0, w, e, r);
      checks++; if (r !== 32'hDE22BE44) begin errors++; $display("FAIL strb_merge got %h required de22be44", r); end
      bus_idle();
      apb_xfer(1'b1, 32'h100, 32'hFFFFFFFF, 4'b0000, 4'd0, w, e, r);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL strb0_err got %b required 0", e); end
      bus_idle();
      apb_xfer(1'b0, 32'h100, 32'h0, 4'h0, 4'd0, w, e, r);
      checks++; if (r !== 32'hDE22BE44) begin errors++; $display("FAIL strb0_data got %h required de22be44", r); end
      bus_idle();
   endtask

   task automatic test_back_to_back();
      int w; logic e; logic [31:0] r;
      apb_xfer(1'b1, 32'h004, 32'hA5A5_0F0F, 4'hF, 4'd3, w, e, r);
      checks++; if (w !== 3) begin errors++; $display("FAIL wait3_waits got %0d required 3", w); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL wait3_err got %b required 0", e); end
      apb_xfer(1'b0, 32'h004, 32'h0, 4'h0, 4'd0, w, e, r);
      checks++; if (w !== 0) begin errors++; $display("FAIL b2b_waits got %0d required 0", w); end
      checks++; if (r !== 32'hA5A50F0F) begin errors++; $display("FAIL b2b_data got %h required a5a50f0f", r); end
      apb_xfer(1'b0, 32'h100, 32'h0, 4'h0, 4'd1, w, e, r);
      checks++; if (w !== 1 || r !== 32'hDE22BE44) begin errors++; $display("FAIL b2b2_read got waits=%0d data=%h required waits=1 data=de22be44", w, r); end
      bus_idle();
   endtask

   task automatic test_errors();
      int w; logic e; logic [31:0] r;
      apb_xfer(1'b0, 32'h102, 32'h0, 4'h0, 4'd0, w, e, r);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL misalign_err got %b required 1", e); end
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL misalign_data got %h required 0", r); end
      bus_idle();
      apb_xfer(1'b1, 32'h000, 32'hCAFEF00D, 4'hF, 4'd0, w, e, r);
      bus_idle();
      apb_xfer(1'b1, 32'h400, 32'h12345678, 4'hF, 4'd0, w, e, r);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_err got %b required 1", e); end
      bus_idle();
      apb_xfer(1'b0, 32'h000, 32'h0, 4'h0, 4'd0, w, e, r);
      checks++; if (r !== 32'hCAFEF00D) begin errors++; $display("FAIL oor_nowrite got %h required cafef00d", r); end
      bus_idle();
      apb_xfer(1'b0, 32'h000, 32'h0, 4'h1, 4'd0, w, e, r);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL rdstrb_err got %b required 1", e); end
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL rdstrb_data got %h required 0", r); end
      bus_idle();
      @(negedge pclk);
      checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL idle_pslverr got %b required 0", pslverr); end
      @(posedge pclk); #1;
   endtask

   task automatic test_protocol();
      int w; logic e; logic [31:0] r; int seen;
      paddr = 32'h008; pwrite = 1'b1; pwdata = 32'hFFFFFFFF; pstrb = 4'hF; wait_cfg = 4'd0;
      psel = 1'b1; penable = 1'b1;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge pclk);
         if (pready !== 1'b0) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL noset_pready got %0d high cycles required 0", seen); end
      @(posedge pclk); #1;
      bus_idle();
      apb_xfer(1'b1, 32'h040, 32'h01020304, 4'hF, 4'd0, w, e, r);
      bus_idle();
      paddr = 32'h040; pwrite = 1'b1; pwdata = 32'hFFFFFFFF; pstrb = 4'hF; wait_cfg = 4'd3;
      psel = 1'b1; penable = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      psel = 1'b0;
      @(posedge pclk); #1;
      @(negedge pclk);
      checks++; if (pready !== 1'b0) begin errors++; $display("FAIL abort_pready got %b required 0", pready); end
      @(posedge pclk); #1;
      penable = 1'b0;
      repeat (4) @(posedge pclk);
      #1;
      apb_xfer(1'b0, 32'h040, 32'h0, 4'h0, 4'd0, w, e, r);
      checks++; if (r !== 32'h01020304) begin errors++; $display("FAIL abort_nowrite got %h required 01020304", r); end
      bus_idle();
   endtask

   task automatic test_reset_mid();
      int w; logic e; logic [31:0] r;
      apb_xfer(1'b1, 32'h020, 32'h12345678, 4'hF, 4'd0, w, e, r);
      bus_idle();
      apb_xfer(1'b0, 32'h020, 32'h0, 4'h0, 4'd0, w, e, r);
      paddr = 32'h020; pwrite = 1'b1; pwdata = 32'hAAAA5555; pstrb = 4'hF; wait_cfg = 4'd3;
      psel = 1'b1; penable = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      prstn = 1'b0;
      @(posedge pclk); #1;
      prstn = 1'b1;
      @(negedge pclk);
      checks++; if (pready !== 1'b0) begin errors++; $display("FAIL midrst_pready got %b required 0", pready); end
      checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL midrst_pslverr got %b required 0", pslverr); end
      checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL midrst_prdata got %h required 0", prdata); end
      @(posedge pclk); #1;
      bus_idle();
      apb_xfer(1'b0, 32'h020, 32'h0, 4'h0, 4'd0, w, e, r);
      checks++; if (r !== 32'h12345678) begin errors++; $display("FAIL midrst_nowrite got %h required 12345678", r); end
      bus_idle();
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_strobes();
      test_back_to_back();
      test_errors();
      test_protocol();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
APB4 completer (slave) memory that sits directly downstream of the APB master driver on the shared APB bus signals. It answers every transfer addressed to its select bit with a word read or a byte-strobed write into an internal register array. Wait states are programmable and insertable per transfer. Error responses cover misaligned, out-of-range and malformed accesses. The verification environment uses it as the reference slave for master-side agents, and it is also usable as a small RTL scratch RAM.

Parameters:
ADDR_WIDTH, 32, width of paddr
DATA_WIDTH, 32, width of pwdata/prdata; must be 32
STRB_WIDTH, DATA_WIDTH/8, width of pstrb
SEL_WIDTH, 1, width of psel bus
SEL_IDX, 0, index of the psel bit that selects this slave
BASE_ADDR, 32'h0000_0000, byte address of word 0
DEPTH, 256, number of 32-bit words (power of two, 2..4096)

Ports:
pclk  input  1  APB clock; all logic on the rising edge
prstn  input  1  synchronous reset, active-low
paddr  input  ADDR_WIDTH  byte address
psel  input  SEL_WIDTH  select bus; only psel[SEL_IDX] is used
penable  input  1  access-phase indicator
pwrite  input  1  1 = write, 0 = read
pwdata  input  DATA_WIDTH  write data
pstrb  input  STRB_WIDTH  write byte strobes
wait_cfg  input  4  wait states for the next transfer; sampled in the setup cycle
prdata  output  DATA_WIDTH  read data
pready  output  1  transfer-complete indicator
pslverr  output  1  error response; qualified by pready

Behaviour:
- Reset: on a posedge with prstn=0, the state goes to IDLE, the wait counter to 0, and prdata to 0. pready and pslverr are therefore 0. Memory contents are not reset.
- sel = psel[SEL_IDX]. Define off = paddr - BASE_ADDR (modulo 2^ADDR_WIDTH) and idx = off[2 +: log2(DEPTH)].
- Two states: IDLE and ACCESS.
- IDLE, when sel=1 and penable=0 (setup phase):
  - Latch pwrite, idx, pwdata and pstrb.
  - Load wcnt <= wait_cfg.
  - Set err = (paddr[1:0]!=0) | (off >= DEPTH*4) | (!pwrite & pstrb!=0).
  - Set prdata <= (!pwrite & !err) ? mem[idx] : 0.
  - Go to ACCESS.
- IDLE, otherwise: stay in IDLE. penable=1 without a preceding setup cycle is ignored: pready stays 0 and there is no memory effect.
- pready = (state==ACCESS) & (wcnt==0). This is combinational from registers, with no dependency on the current inputs.
- pslverr = pready & err; it is 0 whenever pready is 0.
- ACCESS, when sel=1 and penable=1:
  - If wcnt!=0, decrement wcnt and stay in ACCESS.
  - If wcnt==0, the transfer completes at this edge. For a write with err=0, each byte b with latched pstrb[b]=1 is written: mem[idx][8b+7:8b] <= pwdata byte b. Then go to IDLE.
- ACCESS, when sel=0 (master abort): go to IDLE with no write and prdata <= 0.
- Latency: with wait_cfg=N, pready rises N+1 cycles after the setup edge, so a transfer takes N+2 bus cycles in total.
- Back-to-back transfers: the slave sits in IDLE for the cycle after completion. A setup phase presented in that cycle is accepted normally, with no idle cycle required by the slave.
- Strobes: a write with pstrb=0 completes with pslverr=0 and leaves memory unchanged.
- Out-of-range and misaligned accesses never modify memory, and reads return prdata=0.
- paddr, pwrite, pwdata and pstrb changing during ACCESS are ignored; the setup-phase values are used.
- Reset asserted mid-transfer: return to IDLE on that edge and drop any pending write.
- prdata holds its value until the next setup or abort. It is 0 after writes and errors.

Test Plan:
- Zero-wait write then read: write 0x100 = 0xDEADBEEF with pstrb=4'hF and wait_cfg=0 -> pready in the first ACCESS cycle with pslverr=0. Reading 0x100 -> prdata=0xDEADBEEF with pready in the first ACCESS cycle.
- Byte strobes: write 0x100 = 0x11223344 with pstrb=4'b0101 over 0xDEADBEEF -> a read of 0x100 returns 0xDE22BE44. A write with pstrb=0 leaves the value unchanged, with pslverr=0.
- Wait states: wait_cfg=3 -> pready low for 3 ACCESS cycles and high on the 4th. The transfer is 5 cycles total, and a back-to-back setup in the next cycle is accepted.
- Errors:
  - Read at 0x102 (misaligned) -> pslverr=1, prdata=0.
  - Write at BASE_ADDR+0x400 with DEPTH=256 -> pslverr=1, and memory is unchanged (word 0 still reads its old value).
  - Read with pstrb=4'h1 -> pslverr=1.
- Protocol robustness:
  - penable=1 with sel=1 while in IDLE and no setup -> pready stays 0.
  - psel dropped during a wait state of a write -> return to IDLE, and the target word is unchanged.
- Reset mid-transfer: assert prstn=0 during the second wait cycle of a write -> the next cycle has pready=0, pslverr=0, prdata=0, and the write is not committed.
